// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage for the mini MIPS datapath. Holds the program
// counter, issues word reads to a synchronous instruction memory and presents
// each fetched 16-bit instruction to the decode side over a valid/ready
// handshake. Supports PC redirect for branches/jumps and stops on HALT_OP.
//
// Ports:
//   clk          in   clock; all state updates on its rising edge
//   reset        in   synchronous active-high reset
//   imem_rd      out  read strobe to instruction memory (REQ state only)
//   imem_addr    out  word address, always the current PC
//   imem_data    in   read data, valid one cycle after imem_rd
//   redirect     in   load redirect_pc and flush the current fetch
//   redirect_pc  in   redirect target
//   out_valid    out  instr/opcode/pc_out are valid
//   out_ready    in   decode side accepts the presented instruction
//   instr        out  fetched instruction word (registered)
//   opcode       out  instr[15:12] (registered copy)
//   pc_out       out  address the presented instruction came from
//   halted       out  fetch stopped by HALT_OP

module fetch_unit #(
    parameter int          PC_WIDTH = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'b1111
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_rd,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         instr,
    output logic [3:0]          opcode,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                halted
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        HALT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;

    // State register plus the fetch datapath. Redirect overrides everything
    // except reset; an in-flight read in WAIT is simply not captured when a
    // redirect arrives, so the presented registers keep their old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= PC_WIDTH'(RESET_PC);
            instr  <= 16'h0000;
            opcode <= 4'h0;
            pc_out <= '0;
        end else begin
            state <= next_state;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (state == WAIT) begin
                instr  <= imem_data;
                opcode <= imem_data[15:12];
                pc_out <= pc;
                pc     <= pc + PC_WIDTH'(1);
            end
        end
    end

    // Next-state logic. The HALT decision uses the registered opcode of the
    // instruction being accepted, so it is made in the same cycle as the
    // handshake.
    always_comb begin
        next_state = state;
        if (redirect) begin
            next_state = REQ;
        end else begin
            case (state)
                IDLE:    next_state = REQ;
                REQ:     next_state = WAIT;
                WAIT:    next_state = VALID;
                VALID: begin
                    if (out_ready) begin
                        next_state = (opcode == HALT_OP) ? HALT : REQ;
                    end
                end
                HALT:    next_state = HALT;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs decoded purely from registered state, so there is no
    // combinational path from any input to any output.
    always_comb begin
        imem_rd   = (state == REQ);
        out_valid = (state == VALID);
        halted    = (state == HALT);
        imem_addr = pc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. A transaction-level model (fetch countdown,
// presented word, halt flag) predicts the outputs each cycle and a compare
// process checks them on every falling edge; the stimulus sequence also pins
// hand-computed literal values at key cycles.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [15:0] pc_out;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:65535];

    // Model state
    bit          m_init = 1'b0;
    bit          m_pres;
    bit          m_halt;
    int          m_cnt;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pcout;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    // Behavioural model: m_cnt counts edges until the next word is presented
    // (3 from reset, 2 after a redirect or an acceptance).
    always @(posedge clk) begin
        if (reset) begin
            m_init  = 1'b1;
            m_pc    = 16'h0000;
            m_cnt   = 3;
            m_pres  = 1'b0;
            m_halt  = 1'b0;
            m_instr = 16'h0000;
            m_pcout = 16'h0000;
        end else if (m_init) begin
            if (redirect) begin
                m_pc   = redirect_pc;
                m_cnt  = 2;
                m_pres = 1'b0;
                m_halt = 1'b0;
            end else if (m_halt) begin
                m_cnt = 0;
            end else if (m_pres) begin
                if (out_ready) begin
                    m_pres = 1'b0;
                    if (m_instr[15:12] == 4'hF) m_halt = 1'b1;
                    else m_cnt = 2;
                end
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_instr = mem[m_pc];
                    m_pcout = m_pc;
                    m_pc    = m_pc + 16'd1;
                    m_pres  = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdr, input logic [15:0] rdr_pc, input logic rdy);
        reset       = rst;
        redirect    = rdr;
        redirect_pc = rdr_pc;
        out_ready   = rdy;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("model out_valid", {31'd0, out_valid}, {31'd0, m_pres});
            checkOutput("model halted", {31'd0, halted}, {31'd0, m_halt});
            checkOutput("model imem_rd", {31'd0, imem_rd},
                        {31'd0, (!m_pres && !m_halt && m_cnt == 2)});
            if (!m_pres && !m_halt && m_cnt == 2)
                checkOutput("model imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
            checkOutput("model instr", {16'd0, instr}, {16'd0, m_instr});
            checkOutput("model opcode", {28'd0, opcode}, {28'd0, m_instr[15:12]});
            checkOutput("model pc_out", {16'd0, pc_out}, {16'd0, m_pcout});
        end
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = {4'h3, 12'(a)};
        mem[0] = 16'h0123;
        mem[1] = 16'h1456;
        mem[2] = 16'h2789;
        mem[3] = 16'hF000;

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        // Cycle 0: IDLE after reset
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset instr", {16'd0, instr}, 32'd0);
        checkOutput("reset pc_out", {16'd0, pc_out}, 32'd0);
        checkOutput("reset imem_rd", {31'd0, imem_rd}, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);  // cycle 1: REQ
        checkOutput("first rd", {31'd0, imem_rd}, 32'd1);
        checkOutput("first addr", {16'd0, imem_addr}, 32'h0000);
        @(negedge clk);  // cycle 2: WAIT
        checkOutput("cycle2 out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);  // cycle 3: VALID
        checkOutput("cycle3 out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("word0 instr", {16'd0, instr}, 32'h0123);
        checkOutput("word0 opcode", {28'd0, opcode}, 32'h0);
        @(negedge clk);  // cycle 4: REQ addr 1
        checkOutput("addr1 rd", {31'd0, imem_rd}, 32'd1);
        checkOutput("addr1", {16'd0, imem_addr}, 32'h0001);
        @(negedge clk);  // cycle 5: WAIT
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp instr", {16'd0, instr}, 32'h1456);
            checkOutput("bp opcode", {28'd0, opcode}, 32'h1);
            checkOutput("bp pc_out", {16'd0, pc_out}, 32'h0001);
            checkOutput("bp imem_rd", {31'd0, imem_rd}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);  // REQ addr 2 after acceptance
        checkOutput("addr2 rd", {31'd0, imem_rd}, 32'd1);
        checkOutput("addr2", {16'd0, imem_addr}, 32'h0002);
        repeat (2) @(negedge clk);
        checkOutput("word2 instr", {16'd0, instr}, 32'h2789);
        checkOutput("word2 pc_out", {16'd0, pc_out}, 32'h0002);
        @(negedge clk);
        checkOutput("addr3", {16'd0, imem_addr}, 32'h0003);
        repeat (2) @(negedge clk);
        checkOutput("halt out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("halt opcode", {28'd0, opcode}, 32'hF);
        checkOutput("halt instr", {16'd0, instr}, 32'hF000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("halted flag", {31'd0, halted}, 32'd1);
            checkOutput("halted imem_rd", {31'd0, imem_rd}, 32'd0);
            checkOutput("halted out_valid", {31'd0, out_valid}, 32'd0);
        end
        // Redirect out of HALT to address 0
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("unhalt halted", {31'd0, halted}, 32'd0);
        checkOutput("unhalt rd", {31'd0, imem_rd}, 32'd1);
        checkOutput("unhalt addr", {16'd0, imem_addr}, 32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("refetch pc_out", {16'd0, pc_out}, 32'h0000);
        checkOutput("refetch instr", {16'd0, instr}, 32'h0123);
        repeat (2) @(negedge clk);  // WAIT for address 1
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1);
        @(negedge clk);
        checkOutput("wait-redir rd", {31'd0, imem_rd}, 32'd1);
        checkOutput("wait-redir addr", {16'd0, imem_addr}, 32'h0040);
        checkOutput("wait-redir instr kept", {16'd0, instr}, 32'h0123);
        checkOutput("wait-redir pc_out kept", {16'd0, pc_out}, 32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("wait-redir present", {16'd0, pc_out}, 32'h0040);
        checkOutput("wait-redir word", {16'd0, instr}, 32'h3040);
        // Redirect while VALID with out_ready=1: redirect wins
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
        @(negedge clk);
        checkOutput("valid-redir out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("valid-redir addr", {16'd0, imem_addr}, 32'h0100);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("valid-redir present", {16'd0, pc_out}, 32'h0100);
        // Wrap-around from 0xFFFF
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
        @(negedge clk);
        checkOutput("wrap req addr", {16'd0, imem_addr}, 32'hFFFF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("wrap present", {16'd0, pc_out}, 32'hFFFF);
        checkOutput("wrap instr", {16'd0, instr}, 32'h3FFF);
        @(negedge clk);
        checkOutput("wrap next addr", {16'd0, imem_addr}, 32'h0000);
        checkOutput("wrap next rd", {31'd0, imem_rd}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("pre-reset pc_out", {16'd0, pc_out}, 32'h0001);
        // Reset in VALID together with redirect: reset wins
        applyStimulus(1'b1, 1'b1, 16'h0055, 1'b1);
        @(negedge clk);
        checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset pc_out", {16'd0, pc_out}, 32'h0000);
        checkOutput("midreset halted", {31'd0, halted}, 32'd0);
        checkOutput("midreset imem_rd", {31'd0, imem_rd}, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("post-reset addr", {16'd0, imem_addr}, 32'h0000);
        checkOutput("post-reset rd", {31'd0, imem_rd}, 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("post-reset word", {16'd0, instr}, 32'h0123);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
